// File: rtl/mvm_pkg.sv
// Shared state encoding, defaults and helpers for the MVM control stage
// and its local operand memories.
package mvm_pkg;

    localparam int unsigned MVM_WIDTH    = 14;
    localparam int unsigned MVM_MULT_LAT = 1;

    typedef enum logic [2:0] {
        LOAD_W,
        LOAD_X,
        COMPUTE,
        DRAIN,
        OUT
    } mvm_state_t;

    function automatic int unsigned mvm_addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mvm_memory.sv
// Small synchronous-read RAM, one per operand vector. Contents survive reset;
// only the registered read port is cleared.
module mvm_memory
    import mvm_pkg::*;
#(
    parameter int unsigned WIDTH = MVM_WIDTH,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = mvm_addr_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mvm_ctrl_part2.sv
// Operand sequencer for one MAC: loads N weights and N inputs, streams them
// into the MAC with aligned control taps, and returns the accumulated result.
// Optional weight reuse is enabled by defining MVM_CTRL_WEIGHT_REUSE_EN.
module mvm_ctrl_part2
    import mvm_pkg::*;
#(
    parameter int unsigned WIDTH    = MVM_WIDTH,
    parameter int unsigned N        = 4,
    parameter int unsigned MULT_LAT = MVM_MULT_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [WIDTH-1:0] input_data,
    input  logic             new_matrix,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             enable_mult,
    output logic             en_pipeline_reg,
    output logic             en_acc,
    output logic             clear_acc,
    input  logic [WIDTH-1:0] f,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [WIDTH-1:0] output_data
);

    localparam int unsigned   AW       = mvm_addr_bits(N);
    localparam int unsigned   SR_DEPTH = MULT_LAT + 2;
    localparam logic [AW-1:0] LAST     = AW'(N - 1);

    mvm_state_t state, state_nxt;

    logic [AW-1:0]       wcnt, xcnt, rcnt, acc_cnt;
    logic [SR_DEPTH-1:0] vsr;
    logic                w_we, x_we, rd_en, push;
    logic                start_compute, out_load, out_done;
    logic                reuse_hit;
    logic [AW-1:0]       w_addr, x_addr;

`ifdef MVM_CTRL_WEIGHT_REUSE_EN
    logic w_loaded;

    // First word of a job goes straight to x_mem[0] when the stored weights are kept.
    assign reuse_hit = (wcnt == '0) && !new_matrix && w_loaded;
`else
    logic new_matrix_unused;

    assign new_matrix_unused = new_matrix;
    assign reuse_hit         = 1'b0;
`endif

    assign w_addr = rd_en ? rcnt : wcnt;
    assign x_addr = rd_en ? rcnt : xcnt;

    mvm_memory #(
        .WIDTH(WIDTH),
        .DEPTH(N),
        .AW   (AW)
    ) u_w_mem (
        .clk  (clk),
        .reset(reset),
        .we   (w_we),
        .re   (rd_en),
        .addr (w_addr),
        .wdata(input_data),
        .rdata(b)
    );

    mvm_memory #(
        .WIDTH(WIDTH),
        .DEPTH(N),
        .AW   (AW)
    ) u_x_mem (
        .clk  (clk),
        .reset(reset),
        .we   (x_we),
        .re   (rd_en),
        .addr (x_addr),
        .wdata(input_data),
        .rdata(a)
    );

    assign enable_mult     = vsr[0];
    assign en_pipeline_reg = vsr[MULT_LAT];
    assign en_acc          = vsr[MULT_LAT+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD_W;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        input_ready   = 1'b0;
        w_we          = 1'b0;
        x_we          = 1'b0;
        rd_en         = 1'b0;
        push          = 1'b0;
        start_compute = 1'b0;
        out_load      = 1'b0;
        out_done      = 1'b0;
        case (state)
            LOAD_W: begin
                input_ready = 1'b1;
                if (input_valid) begin
                    if (reuse_hit) begin
                        x_we      = 1'b1;
                        state_nxt = LOAD_X;
                    end else begin
                        w_we = 1'b1;
                        if (wcnt == LAST) begin
                            state_nxt = LOAD_X;
                        end
                    end
                end
            end
            LOAD_X: begin
                input_ready = 1'b1;
                if (input_valid) begin
                    x_we = 1'b1;
                    if (xcnt == LAST) begin
                        start_compute = 1'b1;
                        state_nxt     = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                rd_en = 1'b1;
                push  = 1'b1;
                if (rcnt == LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (en_acc && (acc_cnt == LAST)) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                // First OUT cycle captures f; later cycles wait for the consumer.
                if (!output_valid) begin
                    out_load = 1'b1;
                end else if (output_ready) begin
                    out_done  = 1'b1;
                    state_nxt = LOAD_W;
                end
            end
            default: state_nxt = LOAD_W;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt         <= '0;
            xcnt         <= '0;
            rcnt         <= '0;
            acc_cnt      <= '0;
            vsr          <= '0;
            clear_acc    <= 1'b0;
            output_valid <= 1'b0;
            output_data  <= '0;
        end else begin
            if (w_we) begin
                wcnt <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
            end
            if (x_we) begin
                xcnt <= (xcnt == LAST) ? '0 : xcnt + 1'b1;
            end
            if (rd_en) begin
                rcnt <= (rcnt == LAST) ? '0 : rcnt + 1'b1;
            end
            if (start_compute) begin
                acc_cnt <= '0;
            end else if (en_acc) begin
                acc_cnt <= (acc_cnt == LAST) ? '0 : acc_cnt + 1'b1;
            end
            vsr       <= {vsr[SR_DEPTH-2:0], push};
            clear_acc <= start_compute;
            if (out_load) begin
                output_data  <= f;
                output_valid <= 1'b1;
            end else if (out_done) begin
                output_valid <= 1'b0;
            end
        end
    end

`ifdef MVM_CTRL_WEIGHT_REUSE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            w_loaded <= 1'b0;
        end else if (w_we && (wcnt == LAST)) begin
            w_loaded <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mvm_ctrl_part2.sv
// Bench for mvm_ctrl_part2 with a behavioural saturating MAC attached to its
// control pins; results are compared with a plain-arithmetic dot product.
module tb_mvm_ctrl_part2;

    localparam int unsigned W  = 14;
    localparam int unsigned NV = 4;
    localparam int unsigned ML = 1;

`ifdef MVM_CTRL_WEIGHT_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         input_valid;
    logic         input_ready;
    logic [W-1:0] input_data;
    logic         new_matrix;
    logic [W-1:0] a, b;
    logic         enable_mult, en_pipeline_reg, en_acc, clear_acc;
    logic [W-1:0] f;
    logic         output_valid;
    logic         output_ready;
    logic [W-1:0] output_data;

    int n_tests = 0;
    int n_fail  = 0;
    int wv[4];
    int xv[4];

    always #5 clk = ~clk;

    mvm_ctrl_part2 #(
        .WIDTH   (W),
        .N       (NV),
        .MULT_LAT(ML)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .input_data     (input_data),
        .new_matrix     (new_matrix),
        .a              (a),
        .b              (b),
        .enable_mult    (enable_mult),
        .en_pipeline_reg(en_pipeline_reg),
        .en_acc         (en_acc),
        .clear_acc      (clear_acc),
        .f              (f),
        .output_valid   (output_valid),
        .output_ready   (output_ready),
        .output_data    (output_data)
    );

    function automatic int clamp(input int v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    // Saturating MAC: one multiplier register stage, a pipeline register, an accumulator.
    logic [W-1:0] mult_q, pipe_q, acc_q;
    assign f = acc_q;

    always @(posedge clk) begin
        if (reset) begin
            mult_q <= '0;
            pipe_q <= '0;
            acc_q  <= '0;
        end else begin
            if (enable_mult)
                mult_q <= 14'(clamp(int'($signed(a)) * int'($signed(b))));
            if (en_pipeline_reg)
                pipe_q <= mult_q;
            if (clear_acc)
                acc_q <= '0;
            else if (en_acc)
                acc_q <= 14'(clamp(int'($signed(acc_q)) + int'($signed(pipe_q))));
        end
    end

    int   cyc = 0, clr_total = 0, clr_cyc = 0;
    int   en_total = 0, en_rise_total = 0, en_rise_cyc = 0;
    logic en_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (clear_acc === 1'b1) begin
            clr_total++;
            clr_cyc = cyc;
        end
        if (en_acc === 1'b1) begin
            en_total++;
            if (en_prev !== 1'b1) begin
                en_rise_total++;
                en_rise_cyc = cyc;
            end
        end
        en_prev = en_acc;
    end

    function automatic int ref_dot();
        int acc = 0;
        for (int i = 0; i < 4; i++)
            acc = clamp(acc + clamp(wv[i] * xv[i]));
        return acc;
    endfunction

    function automatic bit pick_nm();
        if (REUSE) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] v, input logic nm, input bit gaps);
        int k = 0;
        if (gaps) repeat ($urandom_range(0, 3)) tick();
        while (input_ready !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        if (input_ready !== 1'b1) chk("input_ready_timeout", input_ready, 1);
        input_data  = v;
        new_matrix  = nm;
        input_valid = 1'b1;
        tick();
        input_valid = 1'b0;
        new_matrix  = 1'b0;
    endtask

    task automatic run_job(input string tag, input bit load_w, input bit nm, input bit gaps,
                           input int stall, input bit junk, input int expv);
        int c0, e0, r0, cnt, bad;
        logic [W-1:0] hold;
        c0 = clr_total;
        e0 = en_total;
        r0 = en_rise_total;
        output_ready = (stall == 0);
        if (load_w)
            for (int i = 0; i < 4; i++) send(14'(wv[i]), (i == 0) ? nm : 1'b0, gaps);
        for (int i = 0; i < 4; i++) send(14'(xv[i]), (!load_w && i == 0) ? nm : 1'b0, gaps);
        chk({tag, ":ready_low_after_load"}, input_ready, 0);
        cnt = 0;
        bad = 0;
        while (output_valid !== 1'b1 && cnt < 40) begin
            if (junk) begin
                input_valid = 1'b1;
                input_data  = 14'($urandom);
            end
            tick();
            cnt++;
            if (input_ready !== 1'b0) bad++;
        end
        input_valid = 1'b0;
        chk({tag, ":latency"}, cnt, 8);
        chk({tag, ":ready_low_busy"}, bad, 0);
        chk({tag, ":result"}, $signed(output_data), expv);
        hold = output_data;
        bad  = 0;
        for (int s = 0; s < stall; s++) begin
            tick();
            if (output_valid !== 1'b1 || output_data !== hold || input_ready !== 1'b0) bad++;
        end
        if (stall > 0) chk({tag, ":stall_stable"}, bad, 0);
        output_ready = 1'b1;
        tick();
        chk({tag, ":valid_drop"}, output_valid, 0);
        chk({tag, ":ready_back"}, input_ready, 1);
        chk({tag, ":clear_pulses"}, clr_total - c0, 1);
        chk({tag, ":en_acc_count"}, en_total - e0, 4);
        chk({tag, ":en_acc_runs"}, en_rise_total - r0, 1);
        chk({tag, ":clear_lead"}, (en_rise_cyc - clr_cyc) >= int'(ML + 2), 1);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ":enable_mult"}, enable_mult, 0);
        chk({tag, ":en_pipeline_reg"}, en_pipeline_reg, 0);
        chk({tag, ":en_acc"}, en_acc, 0);
        chk({tag, ":clear_acc"}, clear_acc, 0);
        chk({tag, ":output_valid"}, output_valid, 0);
        chk({tag, ":a"}, a, 0);
        chk({tag, ":b"}, b, 0);
        chk({tag, ":input_ready"}, input_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        input_valid  = 1'b0;
        input_data   = '0;
        new_matrix   = 1'b0;
        output_ready = 1'b1;
        repeat (3) tick();
        check_quiet("reset");
        chk("reset:output_data", output_data, 0);
        reset = 1'b0;
        tick();

        wv = '{1, 2, 3, 4};
        xv = '{5, 6, 7, 8};
        run_job("basic", 1'b1, 1'b1, 1'b0, 0, 1'b0, 70);

        wv = '{100, 100, 100, 100};
        xv = '{100, 100, 100, 100};
        run_job("sat_pos", 1'b1, 1'b1, 1'b0, 0, 1'b0, 8191);
        xv = '{-100, -100, -100, -100};
        run_job("sat_neg", 1'b1, 1'b1, 1'b0, 0, 1'b0, -8192);

        wv = '{1, 2, 3, 4};
        xv = '{5, 6, 7, 8};
        run_job("stress", 1'b1, 1'b1, 1'b1, 5, 1'b1, 70);

        for (int i = 0; i < 4; i++) send(14'(wv[i]), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(14'(xv[i]), 1'b0, 1'b0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check_quiet("mid_reset");
        tick();
        reset = 1'b0;
        tick();
        run_job("after_reset", 1'b1, 1'b1, 1'b0, 0, 1'b0, 70);

`ifdef MVM_CTRL_WEIGHT_REUSE_EN
        run_job("reuse_job1", 1'b1, 1'b1, 1'b0, 0, 1'b0, 70);
        xv = '{1, 1, 1, 1};
        run_job("reuse_job2", 1'b0, 1'b0, 1'b0, 0, 1'b0, 10);
`else
        xv = '{1, 1, 1, 1};
        run_job("nm_ignored", 1'b1, 1'b0, 1'b0, 0, 1'b0, 10);
`endif

        wv = '{1, 2, 3, 4};
        xv = '{5, 6, 7, 8};
        run_job("b2b_1", 1'b1, 1'b1, 1'b0, 0, 1'b0, 70);
        wv = '{-7, 3, 12, -1};
        xv = '{2, -9, 4, 30};
        run_job("b2b_2", 1'b1, pick_nm(), 1'b0, 0, 1'b0, ref_dot());

        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 4; i++) begin
                if (j % 2 == 0) begin
                    wv[i] = int'($urandom_range(0, 16383)) - 8192;
                    xv[i] = int'($urandom_range(0, 16383)) - 8192;
                end else begin
                    wv[i] = int'($urandom_range(0, 180)) - 90;
                    xv[i] = int'($urandom_range(0, 180)) - 90;
                end
            end
            run_job("random", 1'b1, pick_nm(), 1'b1, int'($urandom_range(0, 4)), (j % 3 == 0), ref_dot());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
